// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller.
// Holds the FSM state encoding and the 2-to-4 decode helper.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [3:0] dec2x4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/fs_using_2x4_decoder.sv
// One-bit full subtractor built on a 2-to-4 decoder of {b, c}.
// diff = a ^ b ^ c, borrow = ~a&(b|c) | b&c.
module fs_using_2x4_decoder
  import serial_subtractor_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  logic [3:0] m;

  // Minterms of {b, c}, then select on the minuend bit
  always_comb begin
    m      = dec2x4({b, c});
    diff   = a ? (m[0] | m[3]) : (m[1] | m[2]);
    borrow = a ? m[3] : (m[1] | m[2] | m[3]);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B controller, LSB first, one cell reused per bit.
// Start/done handshake; diff/borrow_out held until next completion.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic borrow_q, borrow_d;
  logic bout_q, bout_d;

  logic cell_diff;
  logic cell_borrow;

  fs_using_2x4_decoder u_cell (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .c      (borrow_q),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  // Next-state, shifting and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        d_sr_d   = {cell_diff, d_sr_q[WIDTH-1:1]};
        borrow_d = cell_borrow;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = {cell_diff, d_sr_q[WIDTH-1:1]};
          bout_d  = cell_borrow;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags decode straight from state
  always_comb begin
    ready      = (state_q == S_IDLE);
    busy       = (state_q == S_SHIFT);
    done       = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = bout_q;
  end

endmodule
